des_sbox_unit: RTL and testbench

- Parametrised DES S-box substitution engine.
- Accepts one 48-bit word per transaction: the expanded right half XOR the round subkey.
- Returns the 32-bit S1..S8 substitution result through valid/ready handshakes.
- `LANES` sets how many S-boxes are evaluated per cycle, trading area against latency. It sits between the key-mixing XOR and the P-permutation in the iterative DES round datapath.

---
 rtl/des_pkg.sv | 34 +++
 rtl/des_sbox_unit_if.sv | 27 ++
 rtl/des_sbox_lane.sv | 20 ++
 rtl/des_sbox_unit.sv | 126 ++++++++++++
 tb/tb_des_sbox_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// ----------------------------------------------------------------------------
// des_pkg: shared DES S-box tables, lookup helper and S-box unit state type.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package des_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } des_sbox_state_t;

  // Each table is 64 nibbles in FIPS row-major order (row*16 + col), MSB first.
  localparam logic [0:63][3:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] x);
    return SBOX[box][{x[5], x[0], x[4:1]}];
  endfunction

endpackage

`default_nettype wire

// File: rtl/des_sbox_unit_if.sv
// ----------------------------------------------------------------------------
// des_sbox_unit_if: valid/ready input word and output result channels.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface des_sbox_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/des_sbox_lane.sv
// ----------------------------------------------------------------------------
// des_sbox_lane: one combinational S-box evaluation for a selectable box.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module des_sbox_lane
  import des_pkg::*;
(
  input  logic [2:0] box,
  input  logic [5:0] x,
  output logic [3:0] y
);

  assign y = sbox_lookup(box, x);

endmodule

`default_nettype wire

// File: rtl/des_sbox_unit.sv
// ----------------------------------------------------------------------------
// des_sbox_unit: iterative S1..S8 substitution, LANES boxes per cycle.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module des_sbox_unit
  import des_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic            clk,
  input  logic            rst,
  des_sbox_unit_if.slave  bus
);

  localparam int STEPS = 8 / LANES;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
  end

  des_sbox_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [47:0]      latch_q, latch_d;
  logic [31:0]      result_q, result_d;
  logic             out_valid_q, out_valid_d;

  logic [2:0]       lane_box [LANES];
  logic [5:0]       lane_x   [LANES];
  logic [3:0]       lane_y   [LANES];
  logic             accept;
  logic             last_step;

  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_step     = (int'(cnt_q) == STEPS - 1);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = result_q;

  // Box b occupies latch bits [6*(7-b)+5 : 6*(7-b)], S1 at the top.
  always_comb begin
    logic [47:0] shifted;
    for (int l = 0; l < LANES; l++) begin
      lane_box[l] = 3'(int'(cnt_q) * LANES + l);
      shifted     = latch_q >> (6 * (7 - int'(lane_box[l])));
      lane_x[l]   = shifted[5:0];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    des_sbox_lane u_lane (
      .box (lane_box[l]),
      .x   (lane_x[l]),
      .y   (lane_y[l])
    );
  end

  always_comb begin
    int sh;
    state_d     = state_q;
    cnt_d       = cnt_q;
    latch_d     = latch_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    sh          = 0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          latch_d = bus.in_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          sh       = 4 * (7 - int'(lane_box[l]));
          result_d = (result_d & ~(32'hF << sh)) | (32'(lane_y[l]) << sh);
        end
        if (last_step) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            latch_d = bus.in_data;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      latch_q     <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      latch_q     <= latch_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_des_sbox_unit.sv
// ----------------------------------------------------------------------------
// tb_des_sbox_unit: randomized self-checking bench over LANES = 1, 2, 4, 8.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_des_sbox_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid_a;
  logic [3:0]  out_ready_a;
  logic [47:0] in_data_a [4];
  logic [3:0]  in_ready_w;
  logic [3:0]  out_valid_w;
  logic [31:0] out_data_w [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // FIPS 46-3 tables as [box][row][col]
  int T [8][4][16] = '{
    '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7}, '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
      '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0}, '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
    '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10}, '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
      '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15}, '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
    '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8}, '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
      '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7}, '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
    '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15}, '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
      '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4}, '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
    '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9}, '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
      '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14}, '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
    '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11}, '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
      '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6}, '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
    '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1}, '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
      '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2}, '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
    '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7}, '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
      '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8}, '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
  };

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_unit_if bus ();
    assign bus.in_valid   = in_valid_a[g];
    assign bus.in_data    = in_data_a[g];
    assign bus.out_ready  = out_ready_a[g];
    assign in_ready_w[g]  = bus.in_ready;
    assign out_valid_w[g] = bus.out_valid;
    assign out_data_w[g]  = bus.out_data;
    des_sbox_unit #(.LANES(1 << g)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  function automatic logic [31:0] ref_sbox(input logic [47:0] d);
    logic [31:0] r;
    int x, row, col;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      x   = int'((d >> (6 * (7 - b))) & 48'h3F);
      row = (x / 32) * 2 + (x % 2);
      col = (x / 2) % 16;
      r   = (r << 4) | 32'(T[b][row][col]);
    end
    return r;
  endfunction

  function automatic int steps_of(input int k);
    return 8 / (1 << k);
  endfunction

  function automatic logic [47:0] rand48();
    return {16'($urandom), 32'($urandom)};
  endfunction

  // Sends one word on instance k; returns the result and edges from accept to out_valid.
  task automatic run_word(input int k, input logic [47:0] d, output logic [31:0] got, output int lat);
    int n;
    got = 'x;
    lat = -1;
    n   = 0;
    while (!in_ready_w[k] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid_a[k] = 1'b1;
    in_data_a[k]  = d;
    @(posedge clk); #1;
    in_valid_a[k] = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (out_valid_w[k]) begin
        got = out_data_w[k];
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat >= 0 && out_ready_a[k]) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready_w[k] !== 1'b1 || out_valid_w[k] !== 1'b0 || out_data_w[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_values lanes=%0d: in_ready=%b out_valid=%b out_data=%h, want 1 0 00000000",
                 1 << k, in_ready_w[k], out_valid_w[k], out_data_w[k]);
      end
    end
  endtask

  task automatic test_known_vectors();
    logic [31:0] got;
    int lat;
    for (int k = 0; k < 4; k++) begin
      run_word(k, 48'h0, got, lat);
      checks++;
      if (got !== 32'hEFA72C4D) begin
        errors++;
        $display("FAIL zero_vector lanes=%0d: got %h want EFA72C4D", 1 << k, got);
      end
      checks++;
      if (lat !== steps_of(k)) begin
        errors++;
        $display("FAIL zero_latency lanes=%0d: got %0d want %0d", 1 << k, lat, steps_of(k));
      end
      run_word(k, 48'hFFFF_FFFF_FFFF, got, lat);
      checks++;
      if (got !== 32'hD9CE3DCB) begin
        errors++;
        $display("FAIL ones_vector lanes=%0d: got %h want D9CE3DCB", 1 << k, got);
      end
    end
  endtask

  task automatic test_s4_sweep();
    logic [31:0] got;
    logic [47:0] d;
    logic [3:0]  want4;
    int lat;
    for (int k = 0; k < 4; k++) begin
      for (int x = 0; x < 64; x++) begin
        d = 48'(x) << 24;
        run_word(k, d, got, lat);
        checks++;
        if (got !== ref_sbox(d)) begin
          errors++;
          $display("FAIL s4_sweep lanes=%0d x=%0d: got %h want %h", 1 << k, x, got, ref_sbox(d));
        end
        if (x < 4 || x == 63) begin
          want4 = (x == 0) ? 4'd7 : (x == 1) ? 4'd13 : (x == 2) ? 4'd13 : (x == 3) ? 4'd8 : 4'd14;
          checks++;
          if (got[19:16] !== want4) begin
            errors++;
            $display("FAIL s4_nibble lanes=%0d x=%0d: got %0d want %0d", 1 << k, x, got[19:16], want4);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure(input int k);
    logic [47:0] a, b;
    logic [31:0] got;
    int lat;
    a = rand48();
    b = rand48();
    out_ready_a[k] = 1'b0;
    run_word(k, a, got, lat);
    checks++;
    if (got !== ref_sbox(a)) begin
      errors++;
      $display("FAIL bp_first lanes=%0d: got %h want %h", 1 << k, got, ref_sbox(a));
    end
    in_valid_a[k] = 1'b1;
    in_data_a[k]  = b;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid_w[k] !== 1'b1 || out_data_w[k] !== ref_sbox(a) || in_ready_w[k] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold lanes=%0d: out_valid=%b out_data=%h in_ready=%b want 1 %h 0",
                 1 << k, out_valid_w[k], out_data_w[k], in_ready_w[k], ref_sbox(a));
      end
    end
    out_ready_a[k] = 1'b1;
    #1;
    checks++;
    if (in_ready_w[k] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready lanes=%0d: in_ready=%b want 1", 1 << k, in_ready_w[k]);
    end
    @(posedge clk); #1;
    in_valid_a[k] = 1'b0;
    checks++;
    if (out_valid_w[k] !== 1'b0 || in_ready_w[k] !== 1'b0) begin
      errors++;
      $display("FAIL bp_same_cycle_accept lanes=%0d: out_valid=%b in_ready=%b want 0 0",
               1 << k, out_valid_w[k], in_ready_w[k]);
    end
    got = 'x;
    lat = -1;
    for (int c = 0; c < 50; c++) begin
      if (out_valid_w[k]) begin
        got = out_data_w[k];
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (got !== ref_sbox(b) || lat !== steps_of(k)) begin
      errors++;
      $display("FAIL bp_second lanes=%0d: got %h lat %0d want %h lat %0d",
               1 << k, got, lat, ref_sbox(b), steps_of(k));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back(input int k);
    logic [47:0] words [16];
    logic [31:0] exp_q [$];
    logic [31:0] od, e;
    int sent, recv, last_cyc, bound;
    logic in_fire, out_fire;
    for (int i = 0; i < 16; i++) words[i] = rand48();
    sent     = 0;
    recv     = 0;
    last_cyc = 0;
    bound    = 16 * (steps_of(k) + 1) + 20;
    out_ready_a[k] = 1'b1;
    for (int cyc = 0; cyc < bound && recv < 16; cyc++) begin
      in_valid_a[k] = (sent < 16);
      if (sent < 16) in_data_a[k] = words[sent];
      #1;
      in_fire  = in_valid_a[k] && in_ready_w[k];
      out_fire = out_valid_w[k];
      od       = out_data_w[k];
      @(posedge clk); #1;
      if (in_fire) begin
        exp_q.push_back(ref_sbox(words[sent]));
        sent++;
      end
      if (out_fire) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (od !== e) begin
          errors++;
          $display("FAIL b2b_data lanes=%0d idx=%0d: got %h want %h", 1 << k, recv, od, e);
        end
        if (recv > 0) begin
          checks++;
          if (cyc - last_cyc !== steps_of(k) + 1) begin
            errors++;
            $display("FAIL b2b_interval lanes=%0d idx=%0d: got %0d want %0d",
                     1 << k, recv, cyc - last_cyc, steps_of(k) + 1);
          end
        end
        last_cyc = cyc;
        recv++;
      end
    end
    in_valid_a[k] = 1'b0;
    checks++;
    if (recv !== 16) begin
      errors++;
      $display("FAIL b2b_count lanes=%0d: got %0d results want 16", 1 << k, recv);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_busy();
    logic [47:0] d1, d2;
    logic [31:0] got;
    int lat;
    d1 = rand48();
    d2 = rand48();
    in_valid_a[0] = 1'b1;
    in_data_a[0]  = d1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready_w[0] !== 1'b0 || out_valid_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL midbusy_state: in_ready=%b out_valid=%b want 0 0", in_ready_w[0], out_valid_w[0]);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready_w[0] !== 1'b1 || out_valid_w[0] !== 1'b0 || out_data_w[0] !== 32'h0) begin
      errors++;
      $display("FAIL midbusy_async_reset: in_ready=%b out_valid=%b out_data=%h want 1 0 00000000",
               in_ready_w[0], out_valid_w[0], out_data_w[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_word(0, d2, got, lat);
    checks++;
    if (got !== ref_sbox(d2) || lat !== 8) begin
      errors++;
      $display("FAIL midbusy_next_word: got %h lat %0d want %h lat 8", got, lat, ref_sbox(d2));
    end
  endtask

  task automatic test_release_with_valid(input int k);
    logic [47:0] d;
    logic [31:0] got;
    int lat;
    d = rand48();
    @(negedge clk);
    rst = 1'b1;
    in_valid_a[k] = 1'b1;
    in_data_a[k]  = d;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    in_valid_a[k] = 1'b0;
    checks++;
    if (in_ready_w[k] !== 1'b0) begin
      errors++;
      $display("FAIL release_accept lanes=%0d: in_ready=%b want 0 (busy)", 1 << k, in_ready_w[k]);
    end
    got = 'x;
    lat = -1;
    for (int c = 0; c < 50; c++) begin
      if (out_valid_w[k]) begin
        got = out_data_w[k];
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (got !== ref_sbox(d) || lat !== steps_of(k)) begin
      errors++;
      $display("FAIL release_result lanes=%0d: got %h lat %0d want %h lat %0d",
               1 << k, got, lat, ref_sbox(d), steps_of(k));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst         = 1'b1;
    in_valid_a  = '0;
    out_ready_a = '1;
    for (int k = 0; k < 4; k++) in_data_a[k] = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_known_vectors();
    test_s4_sweep();
    test_backpressure(1);
    test_backpressure(0);
    for (int k = 0; k < 4; k++) test_back_to_back(k);
    test_reset_mid_busy();
    test_release_with_valid(1);
    test_release_with_valid(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
